// File: rtl/axil_regtest_pkg.sv
// Shared types and constants for the AXI4-Lite register test master.
package axil_regtest_pkg;

    // Run sequencer states, one per phase of a single register write/read-back.
    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        NEXT,
        FINISH
    } state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic MODE_INCR = 1'b0;
    localparam logic MODE_ROTL = 1'b1;

    localparam int                ERR_W   = 8;
    localparam logic [ERR_W-1:0]  ERR_MAX = '1;

    // Adds up to two errors per cycle, sticking at ERR_MAX instead of wrapping.
    function automatic logic [ERR_W-1:0] err_sat_add(input logic [ERR_W-1:0] cnt,
                                                     input logic [1:0]       inc);
        logic [ERR_W:0] sum;
        sum = {1'b0, cnt} + {{(ERR_W - 1){1'b0}}, inc};
        return sum[ERR_W] ? ERR_MAX : sum[ERR_W-1:0];
    endfunction

endpackage

// File: rtl/axil_regtest_pattern.sv
// Test pattern generator: the value expected in register `index` for a given seed and mode.
module axil_regtest_pattern
    import axil_regtest_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 2
) (
    input  logic [DATA_WIDTH-1:0] seed_i,
    input  logic                  mode_i,
    input  logic [IDX_W-1:0]      index_i,
    output logic [DATA_WIDTH-1:0] pattern_o
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    logic [SH_W-1:0]         rot_amt;
    logic [2*DATA_WIDTH-1:0] rot_full;

    // Incrementing or rotate-left pattern; rotating the doubled word keeps a zero shift exact.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        pattern_o = seed_i;
        rot_amt   = SH_W'(32'(index_i) % DATA_WIDTH);
        rot_full  = {seed_i, seed_i} << rot_amt;
        case (mode_i)
            MODE_INCR: pattern_o = seed_i + DATA_WIDTH'(index_i);
            MODE_ROTL: pattern_o = rot_full[2*DATA_WIDTH-1:DATA_WIDTH];
            default:   pattern_o = seed_i;
        endcase
    end

endmodule

// File: rtl/axil_regtest_master.sv
// AXI4-Lite register test master: writes a pattern to NUM_REGS registers one at a
// time, reads each back, and reports errors, first failing index and watchdog aborts.
module axil_regtest_master
    import axil_regtest_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    NUM_REGS    = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    TIMEOUT_CYC = 1024,
    localparam int                   IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     seed,
    input  logic                      mode,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout,
    output logic [ERR_W-1:0]          err_count,
    output logic [IDX_W-1:0]          fail_index,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam int               WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   seed_q, seed_d;
    logic                    mode_q, mode_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [ERR_W-1:0]        err_q, err_d;
    logic [IDX_W-1:0]        fail_q, fail_d;
    logic                    pass_q, pass_d;
    logic                    timeout_q, timeout_d;

    logic [DATA_WIDTH-1:0]   pattern;
    logic                    aw_now, w_now, wd_expire;
    logic [1:0]              err_inc;

    axil_regtest_pattern #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_pattern (
        .seed_i    (seed_q),
        .mode_i    (mode_q),
        .index_i   (idx_q),
        .pattern_o (pattern)
    );

    // Bus and status outputs decoded from registered state only, so reset clears them at once.
    assign M_AXI_AWVALID = (state_q == WR_REQ) && !aw_done_q;
    assign M_AXI_WVALID  = (state_q == WR_REQ) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == WR_RESP);
    assign M_AXI_ARVALID = (state_q == RD_REQ);
    assign M_AXI_RREADY  = (state_q == RD_DATA);
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = pattern;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;

    assign busy       = (state_q != IDLE) && (state_q != FINISH);
    assign done       = (state_q == FINISH);
    assign pass       = pass_q;
    assign timeout    = timeout_q;
    assign err_count  = err_q;
    assign fail_index = fail_q;

    // Next-state, watchdog and error bookkeeping for one register at a time.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        seed_d    = seed_q;
        mode_d    = mode_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        wd_d      = '0;
        err_d     = err_q;
        fail_d    = fail_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        err_inc   = 2'd0;
        wd_expire = 1'b0;
        aw_now    = aw_done_q | (M_AXI_AWVALID & M_AXI_AWREADY);
        w_now     = w_done_q  | (M_AXI_WVALID  & M_AXI_WREADY);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = WR_REQ;
                    idx_d     = '0;
                    addr_d    = BASE_ADDR;
                    seed_d    = seed;
                    mode_d    = mode;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    err_d     = '0;
                    fail_d    = '0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            WR_REQ: begin
                aw_done_d = aw_now;
                w_done_d  = w_now;
                if (aw_now && w_now)    state_d   = WR_RESP;
                else if (wd_q == WD_LAST) wd_expire = 1'b1;
                else                    wd_d      = wd_q + 1'b1;
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    err_inc = {1'b0, M_AXI_BRESP != RESP_OKAY};
                    state_d = RD_REQ;
                end else if (wd_q == WD_LAST) wd_expire = 1'b1;
                else                          wd_d      = wd_q + 1'b1;
            end
            RD_REQ: begin
                if (M_AXI_ARREADY)            state_d   = RD_DATA;
                else if (wd_q == WD_LAST)     wd_expire = 1'b1;
                else                          wd_d      = wd_q + 1'b1;
            end
            RD_DATA: begin
                if (M_AXI_RVALID) begin
                    err_inc = {1'b0, M_AXI_RRESP != RESP_OKAY} + {1'b0, M_AXI_RDATA != pattern};
                    state_d = NEXT;
                end else if (wd_q == WD_LAST) wd_expire = 1'b1;
                else                          wd_d      = wd_q + 1'b1;
            end
            NEXT: begin
                if (idx_q == IDX_LAST) begin
                    state_d = FINISH;
                end else begin
                    idx_d     = idx_q + 1'b1;
                    addr_d    = addr_q + ADDR_STEP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_REQ;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (wd_expire) begin
            err_inc   = 2'd1;
            timeout_d = 1'b1;
            state_d   = FINISH;
        end

        if (err_inc != 2'd0) begin
            err_d = err_sat_add(err_q, err_inc);
            if (err_q == '0) fail_d = idx_q;
        end

        if ((state_d == FINISH) && (state_q != FINISH)) pass_d = (err_d == '0);
    end

    // State register with asynchronous clear of every control and bus register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!ARESETN) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            addr_q    <= '0;
            seed_q    <= '0;
            mode_q    <= MODE_INCR;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wd_q      <= '0;
            err_q     <= '0;
            fail_q    <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            seed_q    <= seed_d;
            mode_q    <= mode_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            fail_q    <= fail_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_axil_regtest_master.sv
// Randomized bench: a reactive AXI4-Lite slave with configurable stalls and error
// injection, and a run-level reference model of the expected outcome.
module tb_axil_regtest_master;

    localparam int          NR   = 4;
    localparam logic [31:0] BASE = 32'h43C0_0000;
    localparam int          TMO  = 16;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        start = 1'b0;
    logic [31:0] seed = '0;
    logic        mode = 1'b0;

    logic        busy, done, pass, timeout;
    logic [7:0]  err_count;
    logic [1:0]  fail_index;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;

    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    axil_regtest_master #(
        .DATA_WIDTH (32), .ADDR_WIDTH (32), .NUM_REGS (NR),
        .BASE_ADDR  (BASE), .TIMEOUT_CYC (TMO)
    ) dut (
        .ACLK (ACLK), .ARESETN (ARESETN), .start (start), .seed (seed), .mode (mode),
        .busy (busy), .done (done), .pass (pass), .timeout (timeout),
        .err_count (err_count), .fail_index (fail_index),
        .M_AXI_AWADDR (M_AXI_AWADDR), .M_AXI_AWPROT (M_AXI_AWPROT),
        .M_AXI_AWVALID (M_AXI_AWVALID), .M_AXI_AWREADY (awready),
        .M_AXI_WDATA (M_AXI_WDATA), .M_AXI_WSTRB (M_AXI_WSTRB),
        .M_AXI_WVALID (M_AXI_WVALID), .M_AXI_WREADY (wready),
        .M_AXI_BRESP (bresp), .M_AXI_BVALID (bvalid), .M_AXI_BREADY (M_AXI_BREADY),
        .M_AXI_ARADDR (M_AXI_ARADDR), .M_AXI_ARPROT (M_AXI_ARPROT),
        .M_AXI_ARVALID (M_AXI_ARVALID), .M_AXI_ARREADY (arready),
        .M_AXI_RDATA (rdata), .M_AXI_RRESP (rresp), .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave behaviour knobs for the current run.
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly, stall_ar;
    bit          bresp_bad [NR];
    bit          rresp_bad [NR];
    logic [31:0] flip      [NR];

    // Slave state and observations.
    logic [31:0] mem [NR];
    logic [63:0] wr_log [$];
    int          rd_count, proto_err, ar_len, ar_last_len;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit          got_aw, got_w, b_pend, r_pend, b_bad, aw_hs, w_hs, ar_hs;
    logic [31:0] wr_addr, wr_data, rd_addr;
    bit          s_awv, s_wv, s_bready, s_arv, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic finish_sim();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    function automatic int reg_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off[1:0] != 2'b00 || (off >> 2) >= NR) return -1;
        return int'(off >> 2);
    endfunction

    function automatic logic [31:0] pat(input logic [31:0] s, input logic m, input int i);
        int r;
        r = i % 32;
        if (!m) return s + 32'(i);
        if (r == 0) return s;
        return (s << r) | (s >> (32 - r));
    endfunction

    task automatic clear_knobs();
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; stall_ar = -1;
        for (int i = 0; i < NR; i++) begin
            bresp_bad[i] = 1'b0; rresp_bad[i] = 1'b0; flip[i] = '0;
        end
    endtask

    // Reactive slave: everything is evaluated on the falling edge. A handshake happened at
    // the preceding rising edge when both sides were high at the previous falling edge.
    always @(negedge ACLK) begin
        int ri;
        if (!ARESETN) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            bresp = 2'b00; rresp = 2'b00; rdata = '0;
            got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; ar_len = 0;
            s_awv = 0; s_wv = 0; s_bready = 0; s_arv = 0; s_rready = 0;
        end else begin
            aw_hs = s_awv && awready;
            w_hs  = s_wv && wready;
            ar_hs = s_arv && arready;
            if (aw_hs) begin got_aw = 1; wr_addr = s_awaddr; aw_cnt = 0; end
            if (w_hs)  begin got_w = 1;  wr_data = s_wdata;  w_cnt = 0;  end
            if (s_bready && bvalid) bvalid = 0;
            if (ar_hs) begin r_pend = 1; rd_addr = s_araddr; r_cnt = 0; ar_cnt = 0; end
            if (s_rready && rvalid) rvalid = 0;

            if ((aw_hs && M_AXI_AWVALID) || (w_hs && M_AXI_WVALID) || (ar_hs && M_AXI_ARVALID))
                proto_err++;
            if ((M_AXI_ARVALID || M_AXI_RREADY || r_pend || rvalid) &&
                (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_BREADY || got_aw || got_w || b_pend || bvalid))
                proto_err++;

            if (got_aw && got_w) begin
                ri = reg_of(wr_addr);
                wr_log.push_back({wr_addr, wr_data});
                if (ri < 0) proto_err++;
                else        mem[ri] = wr_data;
                b_bad = (ri >= 0) && bresp_bad[ri];
                got_aw = 0; got_w = 0; b_pend = 1; b_cnt = 0;
            end
            if (b_pend) begin
                if (b_cnt >= b_dly) begin
                    bvalid = 1; bresp = b_bad ? 2'b10 : 2'b00; b_pend = 0;
                end else b_cnt++;
            end
            if (r_pend) begin
                if (r_cnt >= r_dly) begin
                    ri = reg_of(rd_addr);
                    rd_count++;
                    rvalid = 1;
                    if (ri < 0) begin
                        proto_err++; rdata = '0; rresp = 2'b00;
                    end else begin
                        rdata = mem[ri] ^ flip[ri];
                        rresp = rresp_bad[ri] ? 2'b10 : 2'b00;
                    end
                    r_pend = 0;
                end else r_cnt++;
            end

            awready = M_AXI_AWVALID && !got_aw && (aw_cnt >= aw_dly);
            if (M_AXI_AWVALID && !awready) aw_cnt++;
            wready = M_AXI_WVALID && !got_w && (w_cnt >= w_dly);
            if (M_AXI_WVALID && !wready) w_cnt++;
            arready = M_AXI_ARVALID && !r_pend && !rvalid && (ar_cnt >= ar_dly) &&
                      (stall_ar < 0 || reg_of(M_AXI_ARADDR) != stall_ar);
            if (M_AXI_ARVALID && !arready) ar_cnt++;

            if (M_AXI_ARVALID) ar_len++;
            else begin
                if (s_arv) ar_last_len = ar_len;
                ar_len = 0;
            end

            s_awv = M_AXI_AWVALID; s_awaddr = M_AXI_AWADDR;
            s_wv  = M_AXI_WVALID;  s_wdata  = M_AXI_WDATA;
            s_bready = M_AXI_BREADY;
            s_arv = M_AXI_ARVALID; s_araddr = M_AXI_ARADDR;
            s_rready = M_AXI_RREADY;
        end
    end

    task automatic tally(input int i, inout int e, inout int fi);
        if (e == 0) fi = i;
        e = (e >= 255) ? 255 : e + 1;
    endtask

    // One complete run: the model predicts the outcome from the knobs, then the DUT is compared.
    task automatic do_run(input logic [31:0] s, input logic m, input bit poke, input bit fin_poke);
        int e_err, e_fi, e_nwr, e_nrd, cyc, n;
        bit e_to;
        e_err = 0; e_fi = 0; e_to = 0; e_nwr = 0; e_nrd = 0;
        for (int i = 0; i < NR; i++) begin
            e_nwr++;
            if (bresp_bad[i]) tally(i, e_err, e_fi);
            if (stall_ar == i) begin
                tally(i, e_err, e_fi);
                e_to = 1;
                break;
            end
            e_nrd++;
            if (rresp_bad[i]) tally(i, e_err, e_fi);
            if (flip[i] != '0) tally(i, e_err, e_fi);
        end

        wr_log.delete(); rd_count = 0; proto_err = 0;
        @(negedge ACLK); start = 1; seed = s; mode = m;
        @(negedge ACLK); start = 0; seed = $urandom; mode = 1'($urandom);
        check("busy_after_start", busy, 1);
        cyc = 0;
        while (!done) begin
            @(negedge ACLK);
            cyc++;
            if (poke && cyc == 5) start = 1;
            if (cyc == 6) start = 0;
            if (cyc > 2000) begin
                check("done_wait", 0, 1);
                finish_sim();
            end
        end
        check("pass", pass, (e_err == 0));
        check("err_count", err_count, e_err);
        check("fail_index", fail_index, e_fi);
        check("timeout", timeout, e_to);
        if (fin_poke) start = 1;
        @(negedge ACLK);
        start = 0;
        check("done_pulse_busy", {done, busy}, 2'b00);
        check("pass_held", pass, (e_err == 0));
        check("n_writes", wr_log.size(), e_nwr);
        n = (wr_log.size() < e_nwr) ? wr_log.size() : e_nwr;
        for (int k = 0; k < n; k++)
            check($sformatf("write%0d", k), wr_log[k], {BASE + 32'(4 * k), pat(s, m, k)});
        check("n_reads", rd_count, e_nrd);
        check("protocol", proto_err, 0);
        if (stall_ar >= 0) check("ar_watchdog_len", ar_last_len, TMO);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_status"}, {busy, done, pass, timeout}, 4'b0000);
        check({tag, "_valid"}, {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
        check({tag, "_counts"}, {err_count, fail_index}, 10'b0);
        check({tag, "_aw_w"}, {M_AXI_AWADDR, M_AXI_WDATA}, 64'b0);
        check({tag, "_ar"}, M_AXI_ARADDR, 32'b0);
    endtask

    initial begin
        int cyc;
        clear_knobs();
        ar_last_len = 0;
        repeat (3) @(negedge ACLK);
        check_reset_outputs("reset");
        check("const_strb_prot", {M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT}, {4'hF, 6'b0});
        ARESETN = 1;

        // Zero-wait slave, INCR from 0101FFFF.
        do_run(32'h0101_FFFF, 1'b0, 0, 0);
        if (wr_log.size() == NR) check("write3_literal", wr_log[3], {32'h43C0_000C, 32'h0102_0002});

        // Address accepted three cycles ahead of data.
        clear_knobs(); w_dly = 3;
        do_run(32'hA5A5_0000, 1'b0, 0, 0);

        // Single read-data corruption on register 2.
        clear_knobs(); flip[2] = 32'h1;
        do_run(32'h1234_5678, 1'b1, 0, 0);

        // Write error on register 1 plus data corruption on register 3.
        clear_knobs(); bresp_bad[1] = 1; flip[3] = 32'h8000_0000;
        do_run(32'hDEAD_BEEF, 1'b0, 0, 0);

        // Read address never accepted: watchdog abort.
        clear_knobs(); stall_ar = 0;
        do_run(32'h0000_0001, 1'b1, 0, 0);

        // Asynchronous reset while a write address is being offered.
        clear_knobs(); aw_dly = 2; w_dly = 2;
        @(negedge ACLK); start = 1; seed = $urandom; mode = 1'b0;
        @(negedge ACLK); start = 0;
        cyc = 0;
        while (!M_AXI_AWVALID && cyc < 50) begin @(negedge ACLK); cyc++; end
        check("awvalid_before_reset", M_AXI_AWVALID, 1);
        #1 ARESETN = 0;
        #1 check_reset_outputs("midrun_reset");
        repeat (2) @(negedge ACLK);
        ARESETN = 1;
        clear_knobs();
        do_run(32'hCAFE_F00D, 1'b0, 0, 0);

        // Randomized runs: stalls, error injection, stray starts while busy and in FINISH.
        for (int r = 0; r < 25; r++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly  = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            r_dly  = $urandom_range(0, 3);
            for (int i = 0; i < NR; i++) begin
                bresp_bad[i] = ($urandom_range(0, 5) == 0);
                rresp_bad[i] = ($urandom_range(0, 5) == 0);
                flip[i] = ($urandom_range(0, 4) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
            end
            stall_ar = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NR - 1)) : -1;
            do_run($urandom, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        finish_sim();
    end

endmodule
